// File: rtl/decade_timer_ctrl_pkg.sv
// Shared types and constants for the decade timer controller and its BCD digits.
package decade_ctrl_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned DIGIT_MAX = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Any non-decimal code collapses to zero so a preset can never hold an illegal digit.
  function automatic logic [DIGIT_W-1:0] sanitize_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(DIGIT_MAX)) ? '0 : d;
  endfunction

endpackage

// File: rtl/decade_timer_ctrl_if.sv
// Command/status bundle between the control logic and the decade timer.
interface decade_timer_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned BCD_W = 4 * DIGITS;

  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [BCD_W-1:0] load_val;
  logic [BCD_W-1:0] limit;
  logic [BCD_W-1:0] bcd;
  logic             running;
  logic             done;
  logic             wrap;
  logic [1:0]       state;

  modport master (
    output start, stop, clear, load, load_val, limit,
    input  bcd, running, done, wrap, state
  );

  modport slave (
    input  start, stop, clear, load, load_val, limit,
    output bcd, running, done, wrap, state
  );

endinterface

// File: rtl/decade_timer_ctrl_bcd_digit.sv
// One mod-10 counter digit: clear beats load beats increment.
module bcd_digit
  import decade_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               co
);

  logic [DIGIT_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (ld) begin
      q_q <= sanitize_digit(d);
    end else if (inc) begin
      q_q <= (q_q == DIGIT_W'(DIGIT_MAX)) ? '0 : q_q + DIGIT_W'(1);
    end
  end

  assign q  = q_q;
  assign co = inc && (q_q == DIGIT_W'(DIGIT_MAX));

endmodule

// File: rtl/decade_timer_ctrl.sv
// Multi-digit BCD event timer: command FSM, tick prescaler, carry chain and limit compare.
module decade_timer_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input logic                clk,
  input logic                rst,
  decade_timer_ctrl_if.slave bus
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               running_q;

  logic               tick_c;
  logic               clr_c;
  logic               ld_c;
  logic               carry_c;
  logic               match_c;
  logic [DIGITS-1:0]  inc_c;
  logic [DIGITS-1:0]  co_c;
  logic [DIGIT_W-1:0] q_c [DIGITS];
  logic [BCD_W-1:0]   next_c;

  // A stop or clear in the tick cycle swallows the tick entirely.
  assign tick_c = (state_q == RUN) && (presc_q == PRE_MAX) && !bus.clear && !bus.stop;

  // Ripple enable: digit i steps only when every lower digit is rolling over.
  always_comb begin
    carry_c = tick_c;
    for (int i = 0; i < int'(DIGITS); i++) begin
      inc_c[i] = carry_c;
      carry_c  = carry_c && (q_c[i] == DIGIT_W'(DIGIT_MAX));
    end
  end

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_digit u_digit (
      .clk (clk),
      .rst (rst),
      .inc (inc_c[i]),
      .clr (clr_c),
      .ld  (ld_c),
      .d   (bus.load_val[i*DIGIT_W +: DIGIT_W]),
      .q   (q_c[i]),
      .co  (co_c[i])
    );

    assign next_c[i*DIGIT_W +: DIGIT_W] =
      !inc_c[i]                          ? q_c[i] :
      (q_c[i] == DIGIT_W'(DIGIT_MAX))    ? '0     : q_c[i] + DIGIT_W'(1);
    assign bus.bcd[i*DIGIT_W +: DIGIT_W] = q_c[i];
  end

  // Post-increment value is always valid BCD, so an invalid limit can never match.
  assign match_c = (next_c == bus.limit);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    clr_c   = 1'b0;
    ld_c    = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      presc_d = '0;
      clr_c   = 1'b1;
    end else if (bus.load && (state_q == IDLE || state_q == PAUSE)) begin
      ld_c = 1'b1;
    end else if (bus.stop && state_q == RUN) begin
      state_d = PAUSE;
    end else if (bus.start && state_q != RUN) begin
      state_d = RUN;
      if (state_q == DONE) begin
        presc_d = '0;
        clr_c   = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (tick_c) begin
        presc_d = '0;
        wrap_d  = &co_c;
        if (match_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == RUN);
    end
  end

  assign bus.state   = state_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_decade_timer_ctrl.sv
// Directed bench for decade_timer_ctrl at TICK_DIV 1, 2 and 4 with two digits.
module tb_decade_timer_ctrl;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  decade_timer_ctrl_if #(.DIGITS(2)) if_d1 ();
  decade_timer_ctrl_if #(.DIGITS(2)) if_d2 ();
  decade_timer_ctrl_if #(.DIGITS(2)) if_d4 ();

  decade_timer_ctrl #(.DIGITS(2), .TICK_DIV(1)) u_d1 (.clk(clk), .rst(rst), .bus(if_d1));
  decade_timer_ctrl #(.DIGITS(2), .TICK_DIV(2)) u_d2 (.clk(clk), .rst(rst), .bus(if_d2));
  decade_timer_ctrl #(.DIGITS(2), .TICK_DIV(4)) u_d4 (.clk(clk), .rst(rst), .bus(if_d4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic [7:0] lv;
    logic [7:0] lim;
    logic [7:0] ebcd;
    logic [1:0] est;
    logic       ed;
    logic       ew;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic p, input logic c, input logic l,
                     input logic [7:0] lv, input logic [7:0] lim,
                     input logic [7:0] eb, input logic [1:0] es,
                     input logic ed, input logic ew);
    vec_t v;
    v.start = s; v.stop = p; v.clear = c; v.load = l;
    v.lv = lv; v.lim = lim; v.ebcd = eb; v.est = es; v.ed = ed; v.ew = ew;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int wraps;
    int wrap_at;
    bit got_done;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    {if_d1.start, if_d1.stop, if_d1.clear, if_d1.load} = 4'b0;
    {if_d2.start, if_d2.stop, if_d2.clear, if_d2.load} = 4'b0;
    {if_d4.start, if_d4.stop, if_d4.clear, if_d4.load} = 4'b0;
    if_d1.load_val = 8'h00; if_d1.limit = 8'h12;
    if_d2.load_val = 8'h00; if_d2.limit = 8'h06;
    if_d4.load_val = 8'h00; if_d4.limit = 8'hAA;

    // Reset held for three cycles.
    repeat (3) step();
    chk("rst_d1_bcd",   if_d1.bcd, 8'h00);
    chk("rst_d1_state", if_d1.state, 2'd0);
    chk("rst_d2_bcd",   if_d2.bcd, 8'h00);
    chk("rst_d2_state", if_d2.state, 2'd0);
    chk("rst_d2_flags", {if_d2.running, if_d2.done, if_d2.wrap}, 3'b000);
    chk("rst_d4_bcd",   if_d4.bcd, 8'h00);
    rst = 1'b1;

    // Table for TICK_DIV=1: every RUN cycle is a tick.
    add(1,0,0,0, 8'h00, 8'h12, 8'h00, 2'd1, 0, 0);
    for (int k = 1; k <= 11; k++)
      add(0,0,0,0, 8'h00, 8'h12, 8'((k / 10) * 16 + (k % 10)), 2'd1, 0, 0);
    add(0,0,0,0, 8'h00, 8'h12, 8'h12, 2'd3, 1, 0);
    add(0,0,0,0, 8'h00, 8'h12, 8'h12, 2'd3, 0, 0);
    add(1,0,0,0, 8'h00, 8'h12, 8'h00, 2'd1, 0, 0);
    add(0,0,0,0, 8'h00, 8'h12, 8'h01, 2'd1, 0, 0);
    add(0,0,1,0, 8'h00, 8'h12, 8'h00, 2'd0, 0, 0);
    add(0,0,0,1, 8'h98, 8'hA0, 8'h98, 2'd0, 0, 0);
    add(1,0,0,0, 8'h00, 8'hA0, 8'h98, 2'd1, 0, 0);
    add(0,0,0,0, 8'h00, 8'hA0, 8'h99, 2'd1, 0, 0);
    add(0,0,0,0, 8'h00, 8'hA0, 8'h00, 2'd1, 0, 1);
    add(0,0,0,0, 8'h00, 8'hA0, 8'h01, 2'd1, 0, 0);
    add(0,1,0,0, 8'h00, 8'hA0, 8'h01, 2'd2, 0, 0);
    add(0,0,0,0, 8'h00, 8'hA0, 8'h01, 2'd2, 0, 0);
    add(1,0,1,1, 8'h55, 8'hA0, 8'h00, 2'd0, 0, 0);
    add(0,0,0,1, 8'hB3, 8'hA0, 8'h03, 2'd0, 0, 0);
    add(0,0,0,1, 8'h9F, 8'hA0, 8'h90, 2'd0, 0, 0);
    add(1,0,0,0, 8'h00, 8'hA0, 8'h90, 2'd1, 0, 0);
    add(0,0,0,1, 8'h11, 8'hA0, 8'h91, 2'd1, 0, 0);
    add(1,1,0,0, 8'h00, 8'hA0, 8'h91, 2'd2, 0, 0);
    add(0,0,0,1, 8'h5A, 8'hA0, 8'h50, 2'd2, 0, 0);
    add(1,0,0,0, 8'h00, 8'h50, 8'h50, 2'd1, 0, 0);
    add(0,0,0,0, 8'h00, 8'h50, 8'h51, 2'd1, 0, 0);
    add(0,0,0,0, 8'h00, 8'h52, 8'h52, 2'd3, 1, 0);
    add(0,1,0,0, 8'h00, 8'h52, 8'h52, 2'd3, 0, 0);
    add(0,0,0,1, 8'h77, 8'h52, 8'h52, 2'd3, 0, 0);
    add(1,0,0,0, 8'h00, 8'h52, 8'h00, 2'd1, 0, 0);
    add(0,0,0,0, 8'h00, 8'h52, 8'h01, 2'd1, 0, 0);
    add(0,0,1,0, 8'h00, 8'h02, 8'h00, 2'd0, 0, 0);

    foreach (vq[i]) begin
      if_d1.start = vq[i].start; if_d1.stop = vq[i].stop;
      if_d1.clear = vq[i].clear; if_d1.load = vq[i].load;
      if_d1.load_val = vq[i].lv; if_d1.limit = vq[i].lim;
      step();
      chk($sformatf("vec%0d_bcd", i),   if_d1.bcd, vq[i].ebcd);
      chk($sformatf("vec%0d_state", i), if_d1.state, vq[i].est);
      chk($sformatf("vec%0d_run", i),   if_d1.running, (vq[i].est == 2'd1));
      chk($sformatf("vec%0d_done", i),  if_d1.done, vq[i].ed);
      chk($sformatf("vec%0d_wrap", i),  if_d1.wrap, vq[i].ew);
    end

    // Limit already passed: 05 with limit 03 must wrap and match on the next pass.
    if_d1.start = 0; if_d1.stop = 0; if_d1.clear = 0;
    if_d1.load = 1; if_d1.load_val = 8'h05; if_d1.limit = 8'h03;
    step();
    if_d1.load = 0; if_d1.start = 1;
    step();
    chk("passed_start_bcd", if_d1.bcd, 8'h05);
    if_d1.start = 0;
    cyc = 0; wraps = 0; wrap_at = -1; got_done = 0;
    while (!got_done && cyc < 200) begin
      step();
      cyc++;
      if (if_d1.wrap) begin wraps++; wrap_at = cyc; end
      if (if_d1.done) got_done = 1;
    end
    chk("passed_done_seen", got_done, 1'b1);
    chk("passed_cycles", cyc, 98);
    chk("passed_wraps", wraps, 1);
    chk("passed_wrap_at", wrap_at, 95);
    chk("passed_bcd", if_d1.bcd, 8'h03);

    // TICK_DIV=4: pause with prescaler at 2 keeps the phase.
    if_d4.start = 1;
    step();
    chk("d4_start_state", if_d4.state, 2'd1);
    if_d4.start = 0;
    step(); step(); step();
    chk("d4_before_tick", if_d4.bcd, 8'h00);
    step();
    chk("d4_first_tick", if_d4.bcd, 8'h01);
    step(); step();
    if_d4.stop = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("d4_pause%0d_bcd", k), if_d4.bcd, 8'h01);
      chk($sformatf("d4_pause%0d_state", k), if_d4.state, 2'd2);
    end
    if_d4.stop = 0; if_d4.start = 1;
    step();
    chk("d4_resume_state", if_d4.state, 2'd1);
    if_d4.start = 0;
    step();
    chk("d4_resume_p1", if_d4.bcd, 8'h01);
    step();
    chk("d4_resume_tick", if_d4.bcd, 8'h02);
    step(); step(); step();
    chk("d4_period_hold", if_d4.bcd, 8'h02);
    step();
    chk("d4_period_tick", if_d4.bcd, 8'h03);

    // TICK_DIV=2: basic run, then reset on a tick that would have hit the limit.
    if_d2.start = 1;
    step();
    chk("d2_start_state", if_d2.state, 2'd1);
    chk("d2_start_running", if_d2.running, 1'b1);
    chk("d2_start_bcd", if_d2.bcd, 8'h00);
    if_d2.start = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("d2_run%0d", k), if_d2.bcd, 8'(k / 2));
    end
    step();
    chk("d2_pre_rst_bcd", if_d2.bcd, 8'h05);
    rst = 1'b0;
    step();
    chk("d2_rst_bcd", if_d2.bcd, 8'h00);
    chk("d2_rst_state", if_d2.state, 2'd0);
    chk("d2_rst_done", if_d2.done, 1'b0);
    chk("d2_rst_wrap", if_d2.wrap, 1'b0);
    chk("d2_rst_running", if_d2.running, 1'b0);
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
